// File: rtl/vmask_set_first.sv
// vmask_set_first: mask producer for vmsbf.m / vmsif.m / vmsof.m.
// Two-stage pipeline over an in-order mask-chunk stream; a "found" flag
// carries the first-set-bit state across the chunks of one instruction.
module vmask_set_first #(
    parameter int unsigned REQ_DATA_WIDTH  = 64,
    parameter int unsigned RESP_DATA_WIDTH = 64,
    parameter int unsigned REQ_ADDR_WIDTH  = 32,
    parameter int unsigned IDX_BITS        = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [REQ_DATA_WIDTH-1:0]  in_m0,
    input  logic                       in_valid,
    input  logic [IDX_BITS-1:0]        in_start_idx,
    input  logic                       in_end,
    input  logic [REQ_ADDR_WIDTH-1:0]  in_addr,
    input  logic [1:0]                 in_opSel,
    output logic [RESP_DATA_WIDTH-1:0] out_vec,
    output logic [IDX_BITS-1:0]        out_idx,
    output logic [REQ_ADDR_WIDTH-1:0]  out_addr,
    output logic                       out_end,
    output logic                       out_valid
);

    localparam int unsigned DW = REQ_DATA_WIDTH;

    localparam logic [1:0] OP_SBF = 2'b00;
    localparam logic [1:0] OP_SIF = 2'b01;
    localparam logic [1:0] OP_SOF = 2'b10;

    // Stage 0 registers
    logic                      s0_valid_q, s0_valid_d;
    logic [DW-1:0]             s0_m_q, s0_m_d;
    logic [IDX_BITS-1:0]       s0_idx_q, s0_idx_d;
    logic                      s0_end_q, s0_end_d;
    logic [REQ_ADDR_WIDTH-1:0] s0_addr_q, s0_addr_d;
    logic [1:0]                s0_op_q, s0_op_d;

    // Cross-chunk state
    logic found_q, found_d;

    // Stage 1 (output) registers
    logic                       out_valid_q, out_valid_d;
    logic [RESP_DATA_WIDTH-1:0] out_vec_q, out_vec_d;
    logic [IDX_BITS-1:0]        out_idx_q, out_idx_d;
    logic [REQ_ADDR_WIDTH-1:0]  out_addr_q, out_addr_d;
    logic                       out_end_q, out_end_d;

    logic          f_c;
    logic [DW-1:0] lb_c;
    logic [DW-1:0] res_c;

    // Stage 0 capture: fields hold the chunk when valid, otherwise zero.
    always_comb begin
        s0_valid_d = 1'b0;
        s0_m_d     = '0;
        s0_idx_d   = '0;
        s0_end_d   = 1'b0;
        s0_addr_d  = '0;
        s0_op_d    = '0;
        if (in_valid) begin
            s0_valid_d = 1'b1;
            s0_m_d     = in_m0;
            s0_idx_d   = in_start_idx;
            s0_end_d   = in_end;
            s0_addr_d  = in_addr;
            s0_op_d    = in_opSel;
        end
    end

    // Stage 1 compute: result mask, next found flag and output fields.
    always_comb begin
        f_c   = (s0_idx_q == '0) ? 1'b0 : found_q;
        lb_c  = s0_m_q & (~s0_m_q + DW'(1));
        res_c = '0;
        if (!f_c) begin
            case (s0_op_q)
                OP_SBF:  res_c = lb_c - DW'(1);
                OP_SIF:  res_c = s0_m_q ^ (s0_m_q - DW'(1));
                OP_SOF:  res_c = lb_c;
                default: res_c = '0;
            endcase
        end

        found_d = found_q;
        if (s0_valid_q) begin
            found_d = s0_end_q ? 1'b0 : (f_c | (s0_m_q != '0));
        end

        out_valid_d = 1'b0;
        out_vec_d   = '0;
        out_idx_d   = '0;
        out_addr_d  = '0;
        out_end_d   = 1'b0;
        if (s0_valid_q) begin
            out_valid_d = 1'b1;
            out_vec_d   = RESP_DATA_WIDTH'(res_c);
            out_idx_d   = s0_idx_q;
            out_addr_d  = s0_addr_q;
            out_end_d   = s0_end_q;
        end
    end

    // Pipeline and found registers; reset wins over any valid input.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_q  <= 1'b0;
            s0_m_q      <= '0;
            s0_idx_q    <= '0;
            s0_end_q    <= 1'b0;
            s0_addr_q   <= '0;
            s0_op_q     <= '0;
            found_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_vec_q   <= '0;
            out_idx_q   <= '0;
            out_addr_q  <= '0;
            out_end_q   <= 1'b0;
        end else begin
            s0_valid_q  <= s0_valid_d;
            s0_m_q      <= s0_m_d;
            s0_idx_q    <= s0_idx_d;
            s0_end_q    <= s0_end_d;
            s0_addr_q   <= s0_addr_d;
            s0_op_q     <= s0_op_d;
            found_q     <= found_d;
            out_valid_q <= out_valid_d;
            out_vec_q   <= out_vec_d;
            out_idx_q   <= out_idx_d;
            out_addr_q  <= out_addr_d;
            out_end_q   <= out_end_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_vec   = out_vec_q;
    assign out_idx   = out_idx_q;
    assign out_addr  = out_addr_q;
    assign out_end   = out_end_q;

endmodule

// File: tb/tb_vmask_set_first.sv
// Bench for vmask_set_first: table vectors, hand sequences for reset and
// gaps, and random instructions checked against a per-element model.
module tb_vmask_set_first;

    localparam int unsigned DW = 64;
    localparam int unsigned AW = 32;
    localparam int unsigned IW = 10;

    logic          clk;
    logic          rst;
    logic [DW-1:0] in_m0;
    logic          in_valid;
    logic [IW-1:0] in_start_idx;
    logic          in_end;
    logic [AW-1:0] in_addr;
    logic [1:0]    in_opSel;
    logic [DW-1:0] out_vec;
    logic [IW-1:0] out_idx;
    logic [AW-1:0] out_addr;
    logic          out_end;
    logic          out_valid;

    vmask_set_first #(
        .REQ_DATA_WIDTH (DW),
        .RESP_DATA_WIDTH(DW),
        .REQ_ADDR_WIDTH (AW),
        .IDX_BITS       (IW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_m0       (in_m0),
        .in_valid    (in_valid),
        .in_start_idx(in_start_idx),
        .in_end      (in_end),
        .in_addr     (in_addr),
        .in_opSel    (in_opSel),
        .out_vec     (out_vec),
        .out_idx     (out_idx),
        .out_addr    (out_addr),
        .out_end     (out_end),
        .out_valid   (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          valid;
        logic          endf;
        logic [IW-1:0] idx;
        logic [AW-1:0] addr;
        logic [DW-1:0] vec;
    } out_t;

    typedef struct {
        logic [DW-1:0] m;
        logic [IW-1:0] idx;
        logic          e;
        logic [AW-1:0] a;
        logic [1:0]    op;
        logic [DW-1:0] exp;
    } vec_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    logic m_found = 1'b0;
    out_t exp_s0 = '0, exp_s1 = '0;
    logic tab_s0 = 1'b0, tab_s1 = 1'b0;
    logic [DW-1:0] tabv_s0 = '0, tabv_s1 = '0;
    vec_t tbl[$];

    // Element-wise reference: walk bits from element 0, tracking "seen".
    function automatic logic [DW-1:0] model_res(input logic [DW-1:0] m, input logic f,
                                                input logic [1:0] op);
        logic [DW-1:0] r;
        logic seen;
        r    = '0;
        seen = f;
        if (op == 2'b11) return r;
        for (int i = 0; i < DW; i++) begin
            case (op)
                2'b00:   r[i] = !seen && !m[i];
                2'b01:   r[i] = !seen;
                default: r[i] = !seen && m[i];
            endcase
            if (m[i]) seen = 1'b1;
        end
        return r;
    endfunction

    // One clock: drive at negedge, advance the expected pipeline, check at edge+1.
    task automatic cycle(input logic r, input logic v, input logic [DW-1:0] m,
                         input logic [IW-1:0] idx, input logic e, input logic [AW-1:0] a,
                         input logic [1:0] op, input logic has_tab, input logic [DW-1:0] tab);
        out_t pend;
        out_t got;
        logic f;
        rst          = r;
        in_valid     = v;
        in_m0        = m;
        in_start_idx = idx;
        in_end       = e;
        in_addr      = a;
        in_opSel     = op;
        pend         = '0;
        if (r) begin
            m_found = 1'b0;
        end else if (v) begin
            f          = (idx == '0) ? 1'b0 : m_found;
            pend.valid = 1'b1;
            pend.endf  = e;
            pend.idx   = idx;
            pend.addr  = a;
            pend.vec   = model_res(m, f, op);
            m_found    = e ? 1'b0 : (f || (m != '0));
        end
        @(posedge clk);
        if (r) begin
            exp_s1 = '0; exp_s0 = '0;
            tab_s1 = 1'b0; tab_s0 = 1'b0;
        end else begin
            exp_s1  = exp_s0;  exp_s0  = pend;
            tab_s1  = tab_s0;  tab_s0  = has_tab && v;
            tabv_s1 = tabv_s0; tabv_s0 = tab;
        end
        #1;
        got = '{valid: out_valid, endf: out_end, idx: out_idx, addr: out_addr, vec: out_vec};
        n_vec++;
        if (got !== exp_s1) begin
            n_err++;
            $display("FAIL out cyc=%0d got v=%0b e=%0b idx=%0h addr=%0h vec=%h want v=%0b e=%0b idx=%0h addr=%0h vec=%h",
                     cyc, got.valid, got.endf, got.idx, got.addr, got.vec,
                     exp_s1.valid, exp_s1.endf, exp_s1.idx, exp_s1.addr, exp_s1.vec);
        end
        if (tab_s1) begin
            n_vec++;
            if (out_vec !== tabv_s1) begin
                n_err++;
                $display("FAIL table_vec cyc=%0d got %h want %h", cyc, out_vec, tabv_s1);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, 2'b00, 1'b0, '0);
    endtask

    task automatic send(input logic [DW-1:0] m, input logic [IW-1:0] idx, input logic e,
                        input logic [1:0] op, input logic has_tab, input logic [DW-1:0] tab);
        cycle(1'b0, 1'b1, m, idx, e, 32'h100 + 32'(idx), op, has_tab, tab);
    endtask

    function automatic logic [DW-1:0] rand_chunk();
        logic [DW-1:0] x;
        case ($urandom_range(0, 3))
            0:       x = '0;
            1:       x = DW'(1) << $urandom_range(0, DW - 1);
            2:       x = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            default: x = {$urandom, $urandom};
        endcase
        return x;
    endfunction

    initial begin
        logic [1:0] op;
        int nch;
        logic drop_end;
        logic [DW-1:0] ones;
        ones = '1;
        rst = 1'b1; in_valid = 1'b0; in_m0 = '0; in_start_idx = '0;
        in_end = 1'b0; in_addr = '0; in_opSel = '0;

        // Reset held two cycles with valid input present, then one idle cycle.
        cycle(1'b1, 1'b1, 64'hFF, '0, 1'b1, 32'h40, 2'b01, 1'b0, '0);
        cycle(1'b1, 1'b1, 64'hFF, '0, 1'b1, 32'h40, 2'b01, 1'b0, '0);
        idle(1);

        // Table vectors, back to back (includes instruction A then B with stale found).
        tbl.push_back('{64'h10, 10'd0, 1'b1, 32'h100, 2'b00, 64'hF});
        tbl.push_back('{64'h10, 10'd0, 1'b1, 32'h100, 2'b01, 64'h1F});
        tbl.push_back('{64'h10, 10'd0, 1'b1, 32'h100, 2'b10, 64'h10});
        tbl.push_back('{64'h0,  10'd0, 1'b0, 32'h200, 2'b00, ones});
        tbl.push_back('{64'h8,  10'd1, 1'b0, 32'h201, 2'b00, 64'h7});
        tbl.push_back('{64'hFF, 10'd2, 1'b1, 32'h202, 2'b00, 64'h0});
        tbl.push_back('{64'h0,  10'd0, 1'b0, 32'h300, 2'b10, 64'h0});
        tbl.push_back('{64'h8,  10'd1, 1'b0, 32'h301, 2'b10, 64'h8});
        tbl.push_back('{64'hFF, 10'd2, 1'b1, 32'h302, 2'b10, 64'h0});
        tbl.push_back('{64'h0,  10'd0, 1'b0, 32'h400, 2'b01, ones});
        tbl.push_back('{64'h0,  10'd1, 1'b0, 32'h401, 2'b01, ones});
        tbl.push_back('{64'h0,  10'd2, 1'b1, 32'h402, 2'b01, ones});
        tbl.push_back('{64'h1,  10'd0, 1'b0, 32'h500, 2'b10, 64'h1});
        tbl.push_back('{64'h1,  10'd1, 1'b1, 32'h501, 2'b10, 64'h0});
        tbl.push_back('{64'h4,  10'd0, 1'b1, 32'h600, 2'b10, 64'h4});
        tbl.push_back('{64'h5,  10'd0, 1'b1, 32'h700, 2'b11, 64'h0});
        tbl.push_back('{64'h8000_0000_0000_0000, 10'd0, 1'b1, 32'h800, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF});
        for (int i = 0; i < tbl.size(); i++)
            cycle(1'b0, 1'b1, tbl[i].m, tbl[i].idx, tbl[i].e, tbl[i].a, tbl[i].op, 1'b1, tbl[i].exp);
        idle(2);

        // Mid-instruction reset: found set by 0x2 must not leak into the next instruction.
        send(64'h2, 10'd0, 1'b0, 2'b00, 1'b1, 64'h1);
        cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, 2'b00, 1'b0, '0);
        send(64'h0, 10'd0, 1'b1, 2'b00, 1'b1, ones);
        idle(2);

        // Gapped chunks: same results as the contiguous case.
        send(64'h0, 10'd0, 1'b0, 2'b00, 1'b1, ones);
        idle(3);
        send(64'h8, 10'd1, 1'b0, 2'b00, 1'b1, 64'h7);
        idle(3);
        send(64'hFF, 10'd2, 1'b1, 2'b00, 1'b1, 64'h0);
        idle(2);

        // Abandoned instruction (no end) followed by a fresh chunk 0.
        send(64'h1, 10'd0, 1'b0, 2'b01, 1'b1, 64'h1);
        send(64'h0, 10'd0, 1'b1, 2'b01, 1'b1, ones);
        idle(2);

        // Random instructions with gaps, dropped ends and occasional reset.
        for (int k = 0; k < 300; k++) begin
            op       = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            nch      = $urandom_range(1, 5);
            drop_end = ($urandom_range(0, 9) == 0);
            for (int c = 0; c < nch; c++) begin
                cycle(1'b0, 1'b1, rand_chunk(), IW'(c),
                      (c == nch - 1) && !drop_end, $urandom, op, 1'b0, '0);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                if ($urandom_range(0, 60) == 0) begin
                    cycle(1'b1, $urandom_range(0, 1) == 1, rand_chunk(), '0, 1'b1, '0, op, 1'b0, '0);
                    break;
                end
            end
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
